// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, default parameters and size helpers for the convolution sequencer
package conv_pkg;

    localparam int LENX_DEF  = 64;
    localparam int LENF_DEF  = 33;
    localparam int P_DEF     = 4;
    localparam int ADDRX_DEF = 6;
    localparam int ADDRF_DEF = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MAC,
        S_DRAIN,
        S_WRITE
    } seq_state_e;

    function automatic int conv_size(input int lenx, input int lenf);
        return lenx - lenf + 1;
    endfunction

    function automatic int conv_ngroup(input int lenx, input int lenf, input int p);
        return (conv_size(lenx, lenf) + p - 1) / p;
    endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// rtl/conv_sequencer_if.sv - buffer handshake and MAC control bundle of the convolution sequencer
interface conv_sequencer_if import conv_pkg::*; #(
    parameter int P     = P_DEF,
    parameter int ADDRX = ADDRX_DEF,
    parameter int ADDRF = ADDRF_DEF
);
    logic                    x_ready;
    logic                    y_space;
    logic [P-1:0][ADDRX-1:0] addr_x;
    logic [ADDRF-1:0]        addr_f;
    logic                    en_acc;
    logic                    clr_acc;
    logic                    y_wr_en;
    logic [ADDRX-1:0]        y_wr_addr;
    logic [P-1:0]            lane_valid;
    logic                    x_release;
    logic                    busy;

    modport master (
        input  x_ready, y_space,
        output addr_x, addr_f, en_acc, clr_acc, y_wr_en, y_wr_addr, lane_valid, x_release, busy
    );

    modport slave (
        output x_ready, y_space,
        input  addr_x, addr_f, en_acc, clr_acc, y_wr_en, y_wr_addr, lane_valid, x_release, busy
    );
endinterface

// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - per-lane x/filter address generation with clamping of lanes past the output size
module conv_addr_gen import conv_pkg::*; #(
    parameter int LENX  = LENX_DEF,
    parameter int LENF  = LENF_DEF,
    parameter int P     = P_DEF,
    parameter int ADDRX = ADDRX_DEF,
    parameter int ADDRF = ADDRF_DEF
) (
    input  logic [ADDRX:0]            base_i,
    input  logic [ADDRX:0]            k_i,
    output logic [P-1:0][ADDRX-1:0]   addr_x_o,
    output logic [ADDRF-1:0]          addr_f_o,
    output logic [P-1:0]              lane_valid_o
);
    localparam int              AW     = ADDRX + 1;
    localparam logic [AW-1:0]   SIZE_W = AW'(conv_size(LENX, LENF));
    localparam logic [ADDRX-1:0] LAST_X = ADDRX'(LENX - 1);

    // Lanes beyond the output size park on the last sample so they never read past the buffer.
    for (genvar i = 0; i < P; i++) begin : g_lane
        logic [AW-1:0] lane_base;
        logic [AW-1:0] lane_addr;
        assign lane_base       = base_i + AW'(i);
        assign lane_addr       = lane_base + k_i;
        assign lane_valid_o[i] = (lane_base < SIZE_W);
        assign addr_x_o[i]     = lane_valid_o[i] ? lane_addr[ADDRX-1:0] : LAST_X;
    end

    assign addr_f_o = ADDRF'(k_i);

endmodule

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - sequences P-lane MAC passes over an x vector, one output group at a time
module conv_sequencer import conv_pkg::*; #(
    parameter int LENX  = LENX_DEF,
    parameter int LENF  = LENF_DEF,
    parameter int P     = P_DEF,
    parameter int ADDRX = ADDRX_DEF,
    parameter int ADDRF = ADDRF_DEF
) (
    input  logic              clk,
    input  logic              reset,
    conv_sequencer_if.master  bus
);
    localparam int            AW     = ADDRX + 1;
    localparam logic [AW-1:0] SIZE_W = AW'(conv_size(LENX, LENF));
    localparam logic [AW-1:0] P_W    = AW'(P);
    localparam logic [AW-1:0] LAST_K = AW'(LENF - 1);

    seq_state_e              state_q, state_d;
    logic [AW-1:0]           base_q, base_d;
    logic [AW-1:0]           k_q, k_d;
    logic [P-1:0][ADDRX-1:0] addr_x_q, addr_x_nxt;
    logic [ADDRF-1:0]        addr_f_q, addr_f_nxt;
    logic [P-1:0]            lane_mask;
    logic                    en_acc_q;
    logic                    clr_acc_q;
    logic                    write_go;
    logic                    last_group;

    // base only moves on a write, so base_q is stable whenever the next state is MAC.
    conv_addr_gen #(
        .LENX  (LENX),
        .LENF  (LENF),
        .P     (P),
        .ADDRX (ADDRX),
        .ADDRF (ADDRF)
    ) u_addr_gen (
        .base_i       (base_q),
        .k_i          (k_d),
        .addr_x_o     (addr_x_nxt),
        .addr_f_o     (addr_f_nxt),
        .lane_valid_o (lane_mask)
    );

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        k_d        = k_q;
        write_go   = 1'b0;
        last_group = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.x_ready) begin
                    state_d = S_CLEAR;
                    base_d  = '0;
                end
            end
            S_CLEAR: begin
                k_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                if (k_q == LAST_K) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: begin
                // A reset in this cycle must not leak a write or release.
                if (bus.y_space && !reset) begin
                    write_go   = 1'b1;
                    base_d     = base_q + P_W;
                    last_group = (base_d >= SIZE_W);
                    state_d    = last_group ? S_IDLE : S_CLEAR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            k_q       <= '0;
            addr_x_q  <= '0;
            addr_f_q  <= '0;
            en_acc_q  <= 1'b0;
            clr_acc_q <= 1'b1;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            k_q     <= k_d;
            if (state_d == S_MAC) begin
                addr_x_q <= addr_x_nxt;
                addr_f_q <= addr_f_nxt;
            end
            // Read data lands one cycle after the address, so accumulate one cycle late.
            en_acc_q  <= (state_q == S_MAC);
            clr_acc_q <= (state_d == S_CLEAR);
        end
    end

    assign bus.addr_x     = addr_x_q;
    assign bus.addr_f     = addr_f_q;
    assign bus.en_acc     = en_acc_q;
    assign bus.clr_acc    = clr_acc_q;
    assign bus.y_wr_en    = write_go;
    assign bus.y_wr_addr  = write_go ? base_q[ADDRX-1:0] : '0;
    assign bus.lane_valid = write_go ? lane_mask : '0;
    assign bus.x_release  = write_go & last_group;
    assign bus.busy       = (state_q != S_IDLE);

endmodule
